// File: rtl/cla_pipelined_adder.sv
// Pipelined carry-lookahead adder: 4-bit CLA groups, GROUPS_PER_STAGE groups per stage, valid/ready on both sides.
// Optional subtract mode (input sub) when CLA_PIPELINED_ADDER_SUB_EN is defined.
module cla_pipelined_adder #(
    parameter int WIDTH            = 16,
    parameter int GROUPS_PER_STAGE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CLA_PIPELINED_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             p,
    output logic             g
);
    localparam int SW = 4 * GROUPS_PER_STAGE;
    localparam int S  = WIDTH / SW;

    logic             w_adv;
    logic [WIDTH-1:0] w_b0;
    logic             w_c0;

    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

`ifdef CLA_PIPELINED_ADDER_SUB_EN
    assign w_b0 = sub ? ~b : b;
    assign w_c0 = sub | cin;
`else
    assign w_b0 = b;
    assign w_c0 = cin;
`endif

    for (genvar k = 0; k < S; k++) begin : g_stg
        localparam int RW   = WIDTH - SW * (k + 1);
        localparam int SUMW = SW * (k + 1);

        logic [SW-1:0]   w_as, w_bs, w_ss;
        logic            w_ci, w_pi, w_gi, w_vi;
        logic            w_co, w_po, w_go;
        logic [SUMW-1:0] w_sum_n;
        logic            w_c, w_gp, w_gg;
        logic [3:0]      w_pb, w_gb, w_cl;

        logic            r_vld, r_c, r_p, r_g;
        logic [SUMW-1:0] r_sum;

        if (k == 0) begin : g_src
            assign w_as    = a[SW-1:0];
            assign w_bs    = w_b0[SW-1:0];
            assign w_ci    = w_c0;
            assign w_pi    = 1'b1;
            assign w_gi    = 1'b0;
            assign w_vi    = in_valid;
            assign w_sum_n = w_ss;
        end else begin : g_src
            assign w_as    = g_stg[k-1].g_opr.r_a[SW-1:0];
            assign w_bs    = g_stg[k-1].g_opr.r_b[SW-1:0];
            assign w_ci    = g_stg[k-1].r_c;
            assign w_pi    = g_stg[k-1].r_p;
            assign w_gi    = g_stg[k-1].r_g;
            assign w_vi    = g_stg[k-1].r_vld;
            assign w_sum_n = {w_ss, g_stg[k-1].r_sum};
        end

        // Bit-level lookahead inside each group, group-level lookahead across the stage.
        // Block P/G fold the lower stages' P/G in as this slice sits above them.
        always_comb begin
            w_c  = w_ci;
            w_po = w_pi;
            w_go = w_gi;
            w_ss = '0;
            w_pb = '0;
            w_gb = '0;
            w_cl = '0;
            w_gp = 1'b0;
            w_gg = 1'b0;
            for (int j = 0; j < GROUPS_PER_STAGE; j++) begin
                w_pb    = w_as[4*j +: 4] ^ w_bs[4*j +: 4];
                w_gb    = w_as[4*j +: 4] & w_bs[4*j +: 4];
                w_cl[0] = w_c;
                w_cl[1] = w_gb[0] | (w_pb[0] & w_c);
                w_cl[2] = w_gb[1] | (w_pb[1] & w_gb[0]) | (w_pb[1] & w_pb[0] & w_c);
                w_cl[3] = w_gb[2] | (w_pb[2] & w_gb[1]) | (w_pb[2] & w_pb[1] & w_gb[0])
                        | (w_pb[2] & w_pb[1] & w_pb[0] & w_c);
                w_ss[4*j +: 4] = w_pb ^ w_cl;
                w_gp = &w_pb;
                w_gg = w_gb[3] | (w_pb[3] & w_gb[2]) | (w_pb[3] & w_pb[2] & w_gb[1])
                     | (w_pb[3] & w_pb[2] & w_pb[1] & w_gb[0]);
                w_c  = w_gg | (w_gp & w_c);
                w_go = w_gg | (w_gp & w_go);
                w_po = w_po & w_gp;
            end
            w_co = w_c;
        end

        // Data registers load only on a real operand set so bubbles leave the outputs untouched.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_vld <= 1'b0;
                r_c   <= 1'b0;
                r_p   <= 1'b0;
                r_g   <= 1'b0;
                r_sum <= '0;
            end else if (w_adv) begin
                r_vld <= w_vi;
                if (w_vi) begin
                    r_c   <= w_co;
                    r_p   <= w_po;
                    r_g   <= w_go;
                    r_sum <= w_sum_n;
                end
            end
        end

        if (k < S - 1) begin : g_opr
            logic [RW-1:0] r_a, r_b, w_au, w_bu;
            if (k == 0) begin : g_up
                assign w_au = a[WIDTH-1:SW];
                assign w_bu = w_b0[WIDTH-1:SW];
            end else begin : g_up
                assign w_au = g_stg[k-1].g_opr.r_a[RW+SW-1:SW];
                assign w_bu = g_stg[k-1].g_opr.r_b[RW+SW-1:SW];
            end
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_adv && w_vi) begin
                    r_a <= w_au;
                    r_b <= w_bu;
                end
            end
        end

        if (k == S - 1) begin : g_last
            logic r_ovf;
            // Carry into the MSB is recovered as sum ^ a ^ b at that bit.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    r_ovf <= 1'b0;
                else if (w_adv && w_vi)
                    r_ovf <= w_co ^ w_ss[SW-1] ^ w_as[SW-1] ^ w_bs[SW-1];
            end
        end
    end

    assign out_valid = g_stg[S-1].r_vld;
    assign sum       = g_stg[S-1].r_sum;
    assign cout      = g_stg[S-1].r_c;
    assign ovf       = g_stg[S-1].g_last.r_ovf;
    assign p         = g_stg[S-1].r_p;
    assign g         = g_stg[S-1].r_g;

endmodule

// File: tb/tb_cla_pipelined_adder.sv
// Self-checking bench for cla_pipelined_adder (WIDTH=16, one group per stage, 4 stages).
module tb_cla_pipelined_adder;
    localparam int W = 16;
    localparam int S = 4;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         p;
        logic         g;
    } res_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         cin = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
`ifdef CLA_PIPELINED_ADDER_SUB_EN
    logic         sub = 1'b0;
`endif
    logic         in_ready, out_valid, cout, ovf, p, g;
    logic [W-1:0] sum;

    int   checks = 0;
    int   errors = 0;
    res_t q[$];
    res_t exp_r;

    cla_pipelined_adder #(.WIDTH(W), .GROUPS_PER_STAGE(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
`ifdef CLA_PIPELINED_ADDER_SUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .p(p), .g(g)
    );

    always #5 clk = ~clk;

    // Plain-arithmetic reference: bb/cc are the effective operand and carry.
    function automatic res_t model(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic cc);
        res_t       r;
        logic [W:0] s, s0;
        s      = {1'b0, aa} + {1'b0, bb} + {{W{1'b0}}, cc};
        s0     = {1'b0, aa} + {1'b0, bb};
        r.sum  = s[W-1:0];
        r.cout = s[W];
        r.ovf  = (aa[W-1] == bb[W-1]) && (s[W-1] != aa[W-1]);
        r.p    = &(aa ^ bb);
        r.g    = s0[W];
        return r;
    endfunction

    function automatic res_t model_in();
`ifdef CLA_PIPELINED_ADDER_SUB_EN
        if (sub) return model(a, ~b, 1'b1);
`endif
        return model(a, b, cin);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Scoreboard: every presented result must match the oldest outstanding set, held or consumed.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", 32'd1, 32'd0);
                end else begin
                    exp_r = q[0];
                    chk("result", {12'd0, sum, cout, ovf, p, g}, {12'd0, exp_r});
                    if (out_ready) void'(q.pop_front());
                end
            end
            if (in_valid && in_ready) q.push_back(model_in());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic single(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic cc);
        a = aa; b = bb; cin = cc; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < S - 1; i++) begin
            @(negedge clk);
            chk("latency_wait", {31'd0, out_valid}, 32'd0);
        end
        @(negedge clk);
        chk("latency_hit", {31'd0, out_valid}, 32'd1);
        tick();
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < 60 && q.size() != 0; i++) tick();
        chk("drain", q.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] sa[4];
        logic [W-1:0] sb[4];
        sa = '{16'h0001, 16'h0003, 16'h1000, 16'hFFFF};
        sb = '{16'h0002, 16'h0004, 16'h0F00, 16'hFFFF};

        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_outputs", {12'd0, sum, cout, ovf, p, g}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        out_ready = 1'b1;

        single(16'hFFFF, 16'h0001, 1'b0);
        single(16'h7FFF, 16'h0001, 1'b0);
        single(16'h5555, 16'hAAAA, 1'b1);

        // Back-to-back stream: results on consecutive cycles.
        for (int i = 0; i < 4; i++) begin
            a = sa[i]; b = sb[i]; cin = 1'b0; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stream_valid", {31'd0, out_valid}, 32'd1);
        end
        @(negedge clk);
        chk("stream_end", {31'd0, out_valid}, 32'd0);
        tick();

        // Back-pressure with a further set waiting at the input.
        for (int i = 0; i < 4; i++) begin
            a = sa[i] ^ 16'h0F0F; b = sb[i] + 16'h0101; cin = i[0]; in_valid = 1'b1;
            tick();
        end
        a = 16'h8000; b = 16'h8000; cin = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
        end
        tick();
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        drain();

        // Randomized traffic with random back-pressure.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a   = W'($urandom);
            b   = W'($urandom);
            cin = 1'($urandom);
            tick();
        end
        drain();

        // Reset with one result presented and three more in flight.
        for (int i = 0; i < 4; i++) begin
            a = sa[i]; b = sb[i]; cin = 1'b1; in_valid = 1'b1;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst = 1'b1;
        q.delete();
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_outputs", {12'd0, sum, cout, ovf, p, g}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_idle", {31'd0, out_valid}, 32'd0);
        end
        tick();

`ifdef CLA_PIPELINED_ADDER_SUB_EN
        sub = 1'b1;
        single(16'h0003, 16'h0005, 1'b0);
        single(16'h8000, 16'h0001, 1'b0);
        sub = 1'b0;
`endif
        single(16'h1234, 16'h4321, 1'b1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cla_pipelined_adder.md
Name: cla_pipelined_adder

Overview:
- Parametrised, pipelined carry-lookahead adder.
- Splits a WIDTH-bit add into 4-bit CLA groups and resolves GROUPS_PER_STAGE groups per pipeline stage, rippling the stage carry through registers.
- Replaces the single fixed-width registered adder in datapaths that need wider operands at higher clock rates.
- Has a valid/ready handshake on both sides, so it can sit between streaming blocks.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be a multiple of 4*GROUPS_PER_STAGE.
- GROUPS_PER_STAGE, 1, number of 4-bit CLA groups resolved per pipeline stage; derived S = WIDTH/(4*GROUPS_PER_STAGE) stages.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- in_valid, input, 1, operand set valid.
- in_ready, output, 1, block can accept an operand set this cycle.
- a, input, WIDTH, operand A.
- b, input, WIDTH, operand B.
- cin, input, 1, carry in.
- out_valid, output, 1, result valid.
- out_ready, input, 1, downstream accepts the result.
- sum, output, WIDTH, a+b+cin modulo 2^WIDTH.
- cout, output, 1, carry out of the MSB.
- ovf, output, 1, signed two's-complement overflow: carry into MSB XOR carry out.
- p, output, 1, block propagate: AND over all bits of (a XOR b).
- g, output, 1, block generate: carry out with cin=0.

Behaviour:
- Reset: asynchronous, active-high; takes effect immediately, independent of clk.
  - All stage valid bits, sum, cout, ovf, p and g clear to 0.
  - in_ready reads 1 once rst deasserts.
  - A reset mid-operation discards every in-flight operand set; no partial result is ever presented.
- Pipeline: S stages, each with a valid bit. Stage k computes sum bits [4*GROUPS_PER_STAGE*k +: 4*GROUPS_PER_STAGE] from the registered carry of stage k-1. For stage 0 that carry is cin.
- Skew: upper operand slices and the partial sum/P/G are carried forward in skew registers, so each result leaves the pipeline aligned.
- Advance: global, adv = !out_valid || out_ready.
  - in_ready = adv.
  - Transfer on input when in_valid && in_ready.
  - When adv is high, every stage shifts by one, and bubbles shift too (no bubble collapsing).
  - When adv is low, all stage registers and outputs hold.
- Latency: an operand set accepted at edge n appears on the outputs with out_valid=1 after edge n+S, given no stalls. Each cycle of adv=0 adds one cycle.
- Throughput: one result per cycle when in_valid and out_ready are held high.
- Output hold: sum, cout, ovf, p and g are stable while out_valid && !out_ready.
- Output when not valid: sum, cout, ovf, p and g hold their last value. Verification checks them only when out_valid=1.
- Width rules:
  - ovf = c[WIDTH] ^ c[WIDTH-1].
  - p and g are the hierarchical combination of the per-group P/G, accumulated stage by stage.
- Simultaneous events: an output consume and an input accept in the same cycle are both honoured.
- S=1 boundary: when WIDTH = 4*GROUPS_PER_STAGE, the block degenerates to a single-stage registered adder with latency 1.

Optional Feature:
- Macro: CLA_PIPELINED_ADDER_SUB_EN.
- Defined: adds input port sub (1 bit, sampled with a and b).
  - sub=1 computes a + ~b + 1; cin is ignored.
  - cout is then the not-borrow; ovf is signed subtract overflow.
  - p and g use the inverted b.
- Undefined: port sub is absent and the block only adds.

Test Plan (WIDTH=16, GROUPS_PER_STAGE=1, S=4):
- Basic add: a=0xFFFF, b=0x0001, cin=0 -> after 4 edges sum=0x0000, cout=1, ovf=0, p=0, g=1.
- Signed overflow: a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1.
- Full propagate: a=0x5555, b=0xAAAA, cin=1 -> sum=0x0000, cout=1, p=1, g=0.
- Streaming: 4 back-to-back sets {1+2, 3+4, 0x1000+0x0F00, 0xFFFF+0xFFFF} with out_ready=1 -> results 0x0003, 0x0007, 0x1F00, 0xFFFE (cout=1) on 4 consecutive cycles from cycle 4.
- Back-pressure: out_ready=0 for 3 cycles while out_valid=1 -> in_ready=0, outputs frozen. Release -> no result lost or duplicated, order preserved.
- Reset mid-flight: assert rst asynchronously with 3 sets in flight -> out_valid=0 immediately, no stale results after release. With CLA_PIPELINED_ADDER_SUB_EN defined: sub=1, a=0x0003, b=0x0005 -> sum=0xFFFE, cout=0.
